// File: rtl/wb_queue.sv
// Write-back queue: buffers execute results, drains one per cycle to the RF.
// Optional WBQ_ZERO_DISCARD_EN drops writes to x0 and masks x0 forwarding.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                     clk,
    input  logic                     rstd,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_wa,
    input  logic [DW-1:0]            in_wd,
    input  logic                     stall,
    output logic [AW-1:0]            wa,
    output logic [DW-1:0]            wr,
    output logic                     wren,
    input  logic [AW-1:0]            ra1,
    input  logic [AW-1:0]            ra2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [DW-1:0]            fw1,
    output logic [DW-1:0]            fw2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic          hit;
        logic [DW-1:0] data;
    } fwd_t;

    logic [AW-1:0] r_mem_wa [DEPTH];
    logic [DW-1:0] r_mem_wd [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wa;
    logic [DW-1:0] r_wr;
    logic          r_wren;

    logic          w_accept;
    logic          w_store;
    logic          w_pop;
    fwd_t          w_f1;
    fwd_t          w_f2;

    assign in_ready = (r_count != CW'(DEPTH));
    assign w_accept = in_valid && in_ready;
    assign w_pop    = (r_count != '0) && !stall;

`ifdef WBQ_ZERO_DISCARD_EN
    assign w_store  = w_accept && (in_wa != '0);
`else
    assign w_store  = w_accept;
`endif

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_store) r_tail <= r_tail + 1'b1;
            if (w_pop) r_head <= r_head + 1'b1;
            r_count <= r_count + CW'(w_store) - CW'(w_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem_wa[r_tail] <= in_wa;
            r_mem_wd[r_tail] <= in_wd;
        end
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            r_wa   <= '0;
            r_wr   <= '0;
            r_wren <= 1'b1;
        end else if (w_pop) begin
            r_wa   <= r_mem_wa[r_head];
            r_wr   <= r_mem_wd[r_head];
            r_wren <= 1'b0;
        end else begin
            r_wren <= 1'b1;
        end
    end

    // Scan oldest to youngest so the youngest match overrides.
    function automatic fwd_t lookup(input logic [AW-1:0] ra);
        fwd_t          res;
        logic [PW-1:0] idx;
        res = '0;
        if (!r_wren && r_wa == ra) res = {1'b1, r_wr};
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_head + PW'(i);
            if (CW'(i) < r_count && r_mem_wa[idx] == ra)
                res = {1'b1, r_mem_wd[idx]};
        end
`ifdef WBQ_ZERO_DISCARD_EN
        if (ra == '0) res = '0;
`endif
        return res;
    endfunction

    always_comb begin
        w_f1 = lookup(ra1);
        w_f2 = lookup(ra2);
    end

    assign hit1  = w_f1.hit;
    assign fw1   = w_f1.data;
    assign hit2  = w_f2.hit;
    assign fw2   = w_f2.data;
    assign wa    = r_wa;
    assign wr    = r_wr;
    assign wren  = r_wren;
    assign count = r_count;

endmodule
